// File: rtl/cfg_stream_loader.sv
// Serializes host configuration frames (start pulse, target ID MSB first, payload LSB first) onto the config chain head.
// Optional header parity check with a sticky error and payload drain: define CFG_STREAM_LOADER_PARITY_EN.
module cfg_stream_loader #(
  parameter int WORD_WIDTH = 32,
  parameter int ID_WIDTH   = 3,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  crst,
  input  logic [WORD_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  cfg_out_start,
  output logic                  cfg_bit_out,
  output logic                  cfg_bit_out_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BIT_IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int ID_IDX_W  = (ID_WIDTH > 1) ? $clog2(ID_WIDTH) : 1;
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(WORD_WIDTH - 1);
  localparam logic [ID_IDX_W-1:0]  FIRST_ID = ID_IDX_W'(ID_WIDTH - 1);
  localparam logic [LEN_WIDTH-1:0] WORD_LEN = LEN_WIDTH'(WORD_WIDTH);
  localparam logic [LEN_WIDTH-1:0] ONE_LEN  = LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ID,
    S_FETCH,
    S_SHIFT,
`ifdef CFG_STREAM_LOADER_PARITY_EN
    S_DRAIN,
`endif
    S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic [ID_IDX_W-1:0]    id_idx_q, id_idx_d;
  logic [WORD_WIDTH-1:0]  word_q, word_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic s_ready_q, s_ready_d;
  logic start_q, start_d;
  logic bit_q, bit_d;
  logic valid_q, valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic                 handshake;
  logic [LEN_WIDTH-1:0] hdr_nbits;
  logic [ID_WIDTH-1:0]  hdr_id;

  assign handshake = s_valid & s_ready_q;
  assign hdr_nbits = s_data[LEN_WIDTH-1:0];
  assign hdr_id    = s_data[LEN_WIDTH+ID_WIDTH-1:LEN_WIDTH];

`ifdef CFG_STREAM_LOADER_PARITY_EN
  logic err_q, err_d;
  logic parity_bad;
  assign parity_bad = s_data[WORD_WIDTH-1] != (^s_data[WORD_WIDTH-2:0]);
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    id_d      = id_q;
    id_idx_d  = id_idx_q;
    word_d    = word_q;
    bit_idx_d = bit_idx_q;
    rem_d     = rem_q;
`ifdef CFG_STREAM_LOADER_PARITY_EN
    err_d     = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          rem_d = hdr_nbits;
`ifdef CFG_STREAM_LOADER_PARITY_EN
          if (parity_bad) begin
            err_d = 1'b1;
            if (hdr_nbits != '0) state_d = S_DRAIN;
          end else
`endif
          if (hdr_nbits != '0) begin
            state_d = S_START;
            id_d    = hdr_id;
          end
        end
      end
      S_START: begin
        state_d  = S_ID;
        id_idx_d = FIRST_ID;
      end
      S_ID: begin
        if (id_idx_q == '0) begin
          state_d = S_FETCH;
        end else begin
          id_idx_d = id_idx_q - 1'b1;
          id_d     = id_q << 1;
        end
      end
      S_FETCH: begin
        if (handshake) begin
          state_d   = S_SHIFT;
          word_d    = s_data;
          bit_idx_d = '0;
        end
      end
      S_SHIFT: begin
        // rem_q counts payload bits still to emit, including the one on the wire now.
        rem_d = rem_q - ONE_LEN;
        if (rem_q == ONE_LEN) begin
          state_d = S_DONE;
        end else if (bit_idx_q == LAST_BIT) begin
          if (handshake) begin
            word_d    = s_data;
            bit_idx_d = '0;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
          word_d    = word_q >> 1;
        end
      end
`ifdef CFG_STREAM_LOADER_PARITY_EN
      S_DRAIN: begin
        if (handshake) begin
          if (rem_q <= WORD_LEN) state_d = S_IDLE;
          else                   rem_d   = rem_q - WORD_LEN;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight out of flops.
    s_ready_d = (state_d == S_IDLE) || (state_d == S_FETCH) ||
                ((state_d == S_SHIFT) && (bit_idx_d == LAST_BIT) && (rem_d > ONE_LEN));
`ifdef CFG_STREAM_LOADER_PARITY_EN
    if (state_d == S_DRAIN) s_ready_d = 1'b1;
`endif
    start_d = (state_d == S_START);
    valid_d = (state_d == S_ID) || (state_d == S_SHIFT);
    bit_d   = 1'b0;
    if (state_d == S_ID)    bit_d = id_d[ID_WIDTH-1];
    if (state_d == S_SHIFT) bit_d = word_d[0];
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (crst) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      id_idx_q  <= '0;
      word_q    <= '0;
      bit_idx_q <= '0;
      rem_q     <= '0;
      s_ready_q <= 1'b0;
      start_q   <= 1'b0;
      bit_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CFG_STREAM_LOADER_PARITY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      id_idx_q  <= id_idx_d;
      word_q    <= word_d;
      bit_idx_q <= bit_idx_d;
      rem_q     <= rem_d;
      s_ready_q <= s_ready_d;
      start_q   <= start_d;
      bit_q     <= bit_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef CFG_STREAM_LOADER_PARITY_EN
      err_q     <= err_d;
`endif
    end
  end

  assign s_ready           = s_ready_q;
  assign cfg_out_start     = start_q;
  assign cfg_bit_out       = bit_q;
  assign cfg_bit_out_valid = valid_q;
  assign busy              = busy_q;
  assign done              = done_q;
`ifdef CFG_STREAM_LOADER_PARITY_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
